// File: rtl/cci_test_rd_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// cci_test_rd_arb_pkg
// Shared types and helpers for the CCI-P c0 read arbiter.
//   C0_ADDR_W            cache-line address width on c0 Tx
//   t_req_idx            requester index (wide enough for up to 8 requesters)
//   t_out_cnt            outstanding-read counter for the default 64-deep credit
//   t_arb_state          quiesce/drain sequencer states
//   mdata_tag()          extract requester index from the top ID bits of mdata
//   mdata_pack()         build {idx, private mdata} for c0 Tx
// ---------------------------------------------------------------------------
package cci_test_rd_arb_pkg;

  localparam int C0_ADDR_W           = 42;
  localparam int MDATA_W             = 16;
  localparam int MAX_REQ_IDX_W       = 3;
  localparam int DEF_MAX_OUTSTANDING = 64;

  typedef logic [MAX_REQ_IDX_W-1:0]              t_req_idx;
  typedef logic [$clog2(DEF_MAX_OUTSTANDING):0]  t_out_cnt;

  typedef enum logic [1:0] {
    ARB_RUN,
    ARB_DRAIN,
    ARB_IDLE
  } t_arb_state;

  // Requester index lives in mdata[15:16-id_bits].
  function automatic logic [7:0] mdata_tag(input logic [MDATA_W-1:0] mdata, input int id_bits);
    return 8'(mdata >> (MDATA_W - id_bits));
  endfunction

  function automatic logic [MDATA_W-1:0] mdata_pack(input t_req_idx idx,
                                                    input logic [MDATA_W-1:0] priv,
                                                    input int id_bits);
    logic [MDATA_W-1:0] mask;
    mask = 16'hFFFF >> id_bits;
    return (16'(idx) << (MDATA_W - id_bits)) | (priv & mask);
  endfunction

endpackage

// File: rtl/cci_test_rd_arbiter_if.sv
// ---------------------------------------------------------------------------
// cci_test_rd_arbiter_if
// Bundles the engine-side request/response signals and the MPF-side c0
// Tx/Rx signals of the read arbiter.
//   modport master : the arbiter (drives req_ready, c0Tx_*, rsp_*)
//   modport slave  : the surroundings (engines + MPF)
// ---------------------------------------------------------------------------
interface cci_test_rd_arbiter_if
  import cci_test_rd_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int ID_BITS = 3
);
  // Engine side
  logic [N_REQ-1:0]                 req_valid;
  logic [N_REQ-1:0]                 req_ready;
  logic [N_REQ-1:0][C0_ADDR_W-1:0]  req_addr;
  logic [N_REQ-1:0][15-ID_BITS:0]   req_mdata;
  logic [N_REQ-1:0]                 rsp_valid;
  logic [15-ID_BITS:0]              rsp_mdata;
  logic [511:0]                     rsp_data;
  // MPF side
  logic                             c0Tx_valid;
  logic [C0_ADDR_W-1:0]             c0Tx_addr;
  logic [15:0]                      c0Tx_mdata;
  logic                             c0TxAlmFull;
  logic                             c0Rx_rdValid;
  logic [15:0]                      c0Rx_mdata;
  logic [511:0]                     c0Rx_data;

  modport master (
    input  req_valid, req_addr, req_mdata, c0TxAlmFull, c0Rx_rdValid, c0Rx_mdata, c0Rx_data,
    output req_ready, rsp_valid, rsp_mdata, rsp_data, c0Tx_valid, c0Tx_addr, c0Tx_mdata
  );

  modport slave (
    output req_valid, req_addr, req_mdata, c0TxAlmFull, c0Rx_rdValid, c0Rx_mdata, c0Rx_data,
    input  req_ready, rsp_valid, rsp_mdata, rsp_data, c0Tx_valid, c0Tx_addr, c0Tx_mdata
  );
endinterface

// File: rtl/cci_test_rr_picker.sv
// ---------------------------------------------------------------------------
// cci_test_rr_picker
// Round-robin picker: grants the first eligible index at or after the
// pointer, wrapping N-1 -> 0; the pointer moves past the winner.
//   clk, reset   clock, synchronous active-high reset
//   elig_i       per-requester eligibility
//   grant_o      one-hot grant (combinational)
//   grant_idx_o  binary index of the grant (valid when |grant_o)
// ---------------------------------------------------------------------------
module cci_test_rr_picker
  import cci_test_rd_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] elig_i,
  output logic [N-1:0] grant_o,
  output t_req_idx     grant_idx_o
);
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
  localparam int SUM_W = PTR_W + 1;

  logic [PTR_W-1:0] ptr_q, ptr_d, idx;
  logic [SUM_W-1:0] sum;
  logic             found;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path holds an old value (no latch).
    grant_o     = '0;
    grant_idx_o = '0;
    ptr_d       = ptr_q;
    found       = 1'b0;
    sum         = '0;
    idx         = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr_q} + SUM_W'(k);
      if (sum >= SUM_W'(N)) sum = sum - SUM_W'(N);
      idx = sum[PTR_W-1:0];
      if (!found && elig_i[idx]) begin
        found          = 1'b1;
        grant_o[idx]   = 1'b1;
        grant_idx_o    = t_req_idx'(idx);
        ptr_d          = (idx == PTR_W'(N - 1)) ? '0 : idx + 1'b1;
      end
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
endmodule

// File: rtl/cci_test_rd_arbiter.sv
// ---------------------------------------------------------------------------
// cci_test_rd_arbiter
// Shares the CCI-P c0 read Tx channel among N_REQ test engines: round-robin
// grant, requester index tagged into the upper mdata bits, responses routed
// back by that tag, per-requester outstanding-read credit, quiesce/drain.
//   clk, reset  clock, synchronous active-high reset
//   bus         cci_test_rd_arbiter_if.master (req/rsp + c0 Tx/Rx)
//   quiesce     request drain; idle rises once nothing is in flight
//   err         sticky: response tag out of range or counter underflow
//   stat_sel    statistics select; stat_value registered result
// Optional feature macro: CCI_TEST_RD_ARB_STATS_EN (grant/stall counters).
// ---------------------------------------------------------------------------
module cci_test_rd_arbiter
  import cci_test_rd_arb_pkg::*;
#(
  parameter int N_REQ           = 4,
  parameter int MAX_OUTSTANDING = 64,
  parameter int ID_BITS         = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  cci_test_rd_arbiter_if.master bus,
  input  logic                  quiesce,
  output logic                  idle,
  output logic                  err,
  input  logic [3:0]            stat_sel,
  output logic [31:0]           stat_value
);
  localparam int CNT_W  = $clog2(MAX_OUTSTANDING) + 1;
  localparam int PRIV_W = 16 - ID_BITS;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUTSTANDING);

  t_arb_state                   state_q;
  logic                         idle_q, err_q;
  logic [N_REQ-1:0][CNT_W-1:0]  cnt_q;
  logic [N_REQ-1:0]             cnt_full, elig, grant, rx_hit;
  t_req_idx                     grant_idx;
  logic [C0_ADDR_W-1:0]         sel_addr;
  logic [PRIV_W-1:0]            sel_mdata;
  logic                         tx_valid_q;
  logic [C0_ADDR_W-1:0]         tx_addr_q;
  logic [15:0]                  tx_mdata_q;
  logic [N_REQ-1:0]             rsp_valid_q;
  logic [PRIV_W-1:0]            rsp_mdata_q;
  logic [511:0]                 rsp_data_q;
  logic [7:0]                   rx_tag;
  logic                         rx_bad;

  assign rx_tag = mdata_tag(bus.c0Rx_mdata, ID_BITS);
  assign rx_bad = bus.c0Rx_rdValid && (rx_tag >= 8'(N_REQ));

  always_comb begin
    cnt_full  = '0;
    rx_hit    = '0;
    sel_addr  = '0;
    sel_mdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cnt_full[i] = (cnt_q[i] == CNT_FULL);
      rx_hit[i]   = bus.c0Rx_rdValid && (rx_tag == 8'(i));
      if (grant[i]) begin
        sel_addr  = bus.req_addr[i];
        sel_mdata = bus.req_mdata[i];
      end
    end
  end

  // quiesce gates grants in the same cycle it rises, before the FSM leaves RUN.
  assign elig = bus.req_valid & ~cnt_full &
                {N_REQ{!reset && (state_q == ARB_RUN) && !quiesce && !bus.c0TxAlmFull}};

  cci_test_rr_picker #(.N(N_REQ)) u_picker (
    .clk         (clk),
    .reset       (reset),
    .elig_i      (elig),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  assign bus.req_ready = grant;

  // Tx and Rx output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_valid_q  <= 1'b0;
      tx_addr_q   <= '0;
      tx_mdata_q  <= '0;
      rsp_valid_q <= '0;
      rsp_mdata_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      tx_valid_q  <= |grant;
      if (|grant) begin
        tx_addr_q  <= sel_addr;
        tx_mdata_q <= mdata_pack(grant_idx, 16'(sel_mdata), ID_BITS);
      end
      // rx_hit only matches in-range tags, so bad tags are dropped here.
      rsp_valid_q <= rx_hit;
      if (bus.c0Rx_rdValid) begin
        rsp_mdata_q <= bus.c0Rx_mdata[PRIV_W-1:0];
        rsp_data_q  <= bus.c0Rx_data;
      end
    end
  end

  // Outstanding-read credit per requester and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (rx_bad) err_q <= 1'b1;
      for (int i = 0; i < N_REQ; i++) begin
        if (rx_hit[i] && cnt_q[i] == '0) err_q <= 1'b1;
        else if (grant[i] && !rx_hit[i]) cnt_q[i] <= cnt_q[i] + 1'b1;
        else if (rx_hit[i] && !grant[i]) cnt_q[i] <= cnt_q[i] - 1'b1;
      end
    end
  end

  // Quiesce/drain sequencer; idle is registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ARB_RUN;
      idle_q  <= 1'b0;
    end else begin
      case (state_q)
        ARB_RUN:   if (quiesce) state_q <= ARB_DRAIN;
        ARB_DRAIN: begin
          if (!quiesce) state_q <= ARB_RUN;
          else if (cnt_q == '0 && !tx_valid_q) begin
            state_q <= ARB_IDLE;
            idle_q  <= 1'b1;
          end
        end
        ARB_IDLE:  if (!quiesce) begin
          state_q <= ARB_RUN;
          idle_q  <= 1'b0;
        end
        default: begin
          state_q <= ARB_RUN;
          idle_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.c0Tx_valid = tx_valid_q;
  assign bus.c0Tx_addr  = tx_addr_q;
  assign bus.c0Tx_mdata = tx_mdata_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_mdata  = rsp_mdata_q;
  assign bus.rsp_data   = rsp_data_q;
  assign idle           = idle_q;
  assign err            = err_q;

`ifdef CCI_TEST_RD_ARB_STATS_EN
  logic [N_REQ-1:0][31:0] grant_cnt_q;
  logic [31:0]            stall_cnt_q, stat_value_q, stat_d;

  always_comb begin
    stat_d = '0;
    for (int i = 0; i < N_REQ; i++)
      if (stat_sel == 4'(i)) stat_d = grant_cnt_q[i];
    if (stat_sel == 4'd15) stat_d = stall_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_cnt_q  <= '0;
      stall_cnt_q  <= '0;
      stat_value_q <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++)
        if (grant[i]) grant_cnt_q[i] <= grant_cnt_q[i] + 1'b1;
      if (bus.c0TxAlmFull && |bus.req_valid) stall_cnt_q <= stall_cnt_q + 1'b1;
      stat_value_q <= stat_d;
    end
  end

  assign stat_value = stat_value_q;
`else
  logic unused_stat_sel;
  assign unused_stat_sel = ^stat_sel;
  assign stat_value      = '0;
`endif
endmodule

// File: tb/tb_cci_test_rd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cci_test_rd_arbiter
// Randomized bench for cci_test_rd_arbiter with a behavioural reference:
// per-requester in-flight counts, a round-robin pointer and a run/drain/idle
// mode, all updated from the arbitration rules once per clock. Each test task
// adds its own scenario-level comparisons.
// ---------------------------------------------------------------------------
module tb_cci_test_rd_arbiter;
  localparam int N    = 4;
  localparam int MAXO = 64;
  localparam int IDB  = 3;
  localparam int PW   = 16 - IDB;
  localparam int M_RUN = 0, M_DRAIN = 1, M_IDLE = 2;

  logic        clk = 1'b0;
  logic        reset, quiesce, idle, err;
  logic [3:0]  stat_sel;
  logic [31:0] stat_value;

  cci_test_rd_arbiter_if #(.N_REQ(N), .ID_BITS(IDB)) bus ();

  cci_test_rd_arbiter #(.N_REQ(N), .MAX_OUTSTANDING(MAXO), .ID_BITS(IDB)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.master),
    .quiesce    (quiesce),
    .idle       (idle),
    .err        (err),
    .stat_sel   (stat_sel),
    .stat_value (stat_value)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  int m_cnt[N];
  int m_ptr = 0, m_mode = M_RUN, m_last_g = -1, m_total = 0;
  bit m_err = 1'b0, m_tx_pend = 1'b0;
  int obs_grants[N];
  int obs_seq[$];

  function automatic int model_out();
    int s = 0;
    for (int i = 0; i < N; i++) s += m_cnt[i];
    return s;
  endfunction

  // First eligible requester at or after the round-robin pointer, or -1.
  task automatic model_pick(output int g);
    g = -1;
    if (reset || m_mode != M_RUN || quiesce || bus.c0TxAlmFull) return;
    for (int k = 0; k < N; k++) begin
      int i = (m_ptr + k) % N;
      if (bus.req_valid[2'(i)] && m_cnt[i] < MAXO) begin
        g = i;
        return;
      end
    end
  endtask

  task automatic rand_req();
    for (int i = 0; i < N; i++) begin
      bus.req_addr[2'(i)]  = 42'({$urandom(), $urandom()});
      bus.req_mdata[2'(i)] = 13'($urandom());
    end
  endtask

  task automatic drive_rsp(input int tag);
    bus.c0Rx_rdValid = 1'b1;
    bus.c0Rx_mdata   = 16'(tag << PW) | 16'($urandom_range(0, (1 << PW) - 1));
    for (int w = 0; w < 16; w++) bus.c0Rx_data[w*32 +: 32] = $urandom();
  endtask

  task automatic no_rsp();
    bus.c0Rx_rdValid = 1'b0;
    bus.c0Rx_mdata   = '0;
    bus.c0Rx_data    = '0;
  endtask

  // One clock: predict, compare combinational grant, advance model, compare registered outputs.
  task automatic tick();
    int g, tag, inc, dec;
    bit rxv, was_rst;
    logic [N-1:0]   e_ready, e_rsp;
    logic [41:0]    e_addr;
    logic [15:0]    e_md;
    logic [PW-1:0]  e_rmd;
    logic [511:0]   e_rdata;
    #2;
    model_pick(g);
    e_ready = '0;
    if (g >= 0) e_ready[2'(g)] = 1'b1;
    checks++;
    if (bus.req_ready !== e_ready) begin
      errors++;
      $display("FAIL req_ready @%0t: got %b expected %b", $time, bus.req_ready, e_ready);
    end
    for (int i = 0; i < N; i++)
      if (bus.req_ready[2'(i)] && bus.req_valid[2'(i)]) begin
        obs_grants[i]++;
        obs_seq.push_back(i);
      end
    e_addr = '0;
    e_md   = '0;
    if (g >= 0) begin
      e_addr = bus.req_addr[2'(g)];
      e_md   = 16'(g << PW) | 16'(bus.req_mdata[2'(g)]);
    end
    rxv     = bus.c0Rx_rdValid;
    tag     = int'(bus.c0Rx_mdata) >> PW;
    e_rmd   = bus.c0Rx_mdata[PW-1:0];
    e_rdata = bus.c0Rx_data;
    was_rst = reset;
    @(posedge clk);
    if (was_rst) begin
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      m_ptr = 0; m_mode = M_RUN; m_err = 1'b0; m_tx_pend = 1'b0;
    end else begin
      case (m_mode)
        M_RUN:   if (quiesce) m_mode = M_DRAIN;
        M_DRAIN: if (!quiesce) m_mode = M_RUN;
                 else if (model_out() == 0 && !m_tx_pend) m_mode = M_IDLE;
        default: if (!quiesce) m_mode = M_RUN;
      endcase
      if (rxv && tag >= N) m_err = 1'b1;
      for (int i = 0; i < N; i++) begin
        inc = (g == i) ? 1 : 0;
        dec = (rxv && tag == i) ? 1 : 0;
        if (dec == 1 && m_cnt[i] == 0) m_err = 1'b1;
        else m_cnt[i] += inc - dec;
      end
      if (g >= 0) begin
        m_ptr = (g + 1) % N;
        m_total++;
      end
      m_tx_pend = (g >= 0);
    end
    m_last_g = g;
    #1;
    e_rsp = '0;
    if (!was_rst && rxv && tag < N) e_rsp[2'(tag)] = 1'b1;
    checks++;
    if (bus.c0Tx_valid !== (g >= 0)) begin
      errors++;
      $display("FAIL c0Tx_valid @%0t: got %b expected %b", $time, bus.c0Tx_valid, g >= 0);
    end
    if (g >= 0) begin
      checks++;
      if (bus.c0Tx_addr !== e_addr || bus.c0Tx_mdata !== e_md) begin
        errors++;
        $display("FAIL c0Tx_payload @%0t: got %h/%h expected %h/%h", $time,
                 bus.c0Tx_addr, bus.c0Tx_mdata, e_addr, e_md);
      end
    end
    checks++;
    if (bus.rsp_valid !== e_rsp) begin
      errors++;
      $display("FAIL rsp_valid @%0t: got %b expected %b", $time, bus.rsp_valid, e_rsp);
    end
    if (|e_rsp) begin
      checks++;
      if (bus.rsp_mdata !== e_rmd || bus.rsp_data !== e_rdata) begin
        errors++;
        $display("FAIL rsp_payload @%0t: got mdata %h expected %h", $time, bus.rsp_mdata, e_rmd);
      end
    end
    checks++;
    if (idle !== (m_mode == M_IDLE) || err !== m_err) begin
      errors++;
      $display("FAIL idle_err @%0t: got %b/%b expected %b/%b", $time, idle, err,
               m_mode == M_IDLE, m_err);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; quiesce = 1'b0; bus.c0TxAlmFull = 1'b0; bus.req_valid = '0;
    no_rsp();
    tick();
    tick();
    reset = 1'b0;
    m_total = 0;
    for (int i = 0; i < N; i++) obs_grants[i] = 0;
    obs_seq.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req_valid = '1;
    for (int c = 0; c < 5; c++) begin
      rand_req();
      tick();
      checks++;
      if (bus.req_ready !== '0 || bus.c0Tx_valid !== 1'b0 || idle !== 1'b0 || err !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc %0d: got ready=%b tx=%b idle=%b err=%b expected all 0",
                 c, bus.req_ready, bus.c0Tx_valid, idle, err);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_fairness();
    do_reset();
    bus.req_valid = '1;
    for (int cyc = 0; cyc < 300 && m_total < 100; cyc++) begin
      rand_req();
      if (m_last_g >= 0) drive_rsp(m_last_g); else no_rsp();
      tick();
    end
    bus.req_valid = '0;
    if (m_last_g >= 0) drive_rsp(m_last_g); else no_rsp();
    tick();
    no_rsp();
    checks++;
    if (obs_seq.size() != 100) begin
      errors++;
      $display("FAIL fair_total: got %0d expected 100", obs_seq.size());
    end
    for (int k = 0; k < obs_seq.size(); k++) begin
      checks++;
      if (obs_seq[k] != k % N) begin
        errors++;
        $display("FAIL fair_order[%0d]: got %0d expected %0d", k, obs_seq[k], k % N);
      end
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (obs_grants[i] != 25) begin
        errors++;
        $display("FAIL fair_share[%0d]: got %0d expected 25", i, obs_grants[i]);
      end
    end
`ifdef CCI_TEST_RD_ARB_STATS_EN
    for (int i = 0; i < N; i++) begin
      stat_sel = 4'(i);
      tick();
      checks++;
      if (stat_value !== 32'd25) begin
        errors++;
        $display("FAIL stat_grants[%0d]: got %0d expected 25", i, stat_value);
      end
    end
    stat_sel = '0;
`endif
  endtask

  task automatic test_credit();
    do_reset();
    bus.req_valid = 4'b0100;
    for (int cyc = 0; cyc < 100 && m_cnt[2] < MAXO; cyc++) begin
      rand_req();
      tick();
    end
    for (int c = 0; c < 3; c++) tick();
    checks++;
    if (obs_grants[2] != 64) begin
      errors++;
      $display("FAIL credit_limit: got %0d expected 64", obs_grants[2]);
    end
    drive_rsp(2);
    tick();
    no_rsp();
    for (int c = 0; c < 4; c++) tick();
    checks++;
    if (obs_grants[2] != 65) begin
      errors++;
      $display("FAIL credit_one_more: got %0d expected 65", obs_grants[2]);
    end
    drive_rsp(2);
    tick();
    drive_rsp(2);
    tick();
    no_rsp();
    for (int c = 0; c < 3; c++) tick();
    checks++;
    if (obs_grants[2] != 67) begin
      errors++;
      $display("FAIL credit_same_cycle: got %0d expected 67", obs_grants[2]);
    end
  endtask

  task automatic test_almfull();
    int n0, last;
    do_reset();
    bus.req_valid = '1;
    for (int c = 0; c < 10; c++) begin
      rand_req();
      if (m_last_g >= 0) drive_rsp(m_last_g); else no_rsp();
      tick();
    end
    n0   = obs_seq.size();
    last = obs_seq[n0 - 1];
    bus.c0TxAlmFull = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (m_last_g >= 0) drive_rsp(m_last_g); else no_rsp();
      tick();
    end
    no_rsp();
    checks++;
    if (obs_seq.size() != n0) begin
      errors++;
      $display("FAIL almfull_block: got %0d grants expected 0", obs_seq.size() - n0);
    end
    bus.c0TxAlmFull = 1'b0;
    tick();
    checks++;
    if (obs_seq.size() != n0 + 1 || obs_seq[obs_seq.size() - 1] != (last + 1) % N) begin
      errors++;
      $display("FAIL almfull_resume: got %0d grants/idx %0d expected 1/%0d",
               obs_seq.size() - n0, obs_seq[obs_seq.size() - 1], (last + 1) % N);
    end
`ifdef CCI_TEST_RD_ARB_STATS_EN
    stat_sel = 4'd15;
    tick();
    checks++;
    if (stat_value !== 32'd10) begin
      errors++;
      $display("FAIL stat_stall: got %0d expected 10", stat_value);
    end
    stat_sel = '0;
`endif
  endtask

  task automatic test_drain();
    int t;
    do_reset();
    bus.req_valid = '1;
    for (int cyc = 0; cyc < 50 && model_out() < 20; cyc++) begin
      rand_req();
      tick();
    end
    quiesce = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    checks++;
    if (obs_seq.size() != 20 || idle !== 1'b0) begin
      errors++;
      $display("FAIL drain_hold: got %0d grants idle=%b expected 20 idle=0", obs_seq.size(), idle);
    end
    for (int c = 0; c < 20 && obs_seq.size() > 0; c++) begin
      t = obs_seq.pop_front();
      drive_rsp(t);
      tick();
    end
    no_rsp();
    checks++;
    if (idle !== 1'b0) begin
      errors++;
      $display("FAIL drain_early_idle: got %b expected 0", idle);
    end
    tick();
    checks++;
    if (idle !== 1'b1) begin
      errors++;
      $display("FAIL drain_idle: got %b expected 1", idle);
    end
    quiesce = 1'b0;
    tick();
    tick();
    checks++;
    if (idle !== 1'b0 || obs_seq.size() < 1) begin
      errors++;
      $display("FAIL drain_resume: got idle=%b grants=%0d expected idle=0 grants>=1",
               idle, obs_seq.size());
    end
    bus.req_valid = '0;
  endtask

  task automatic test_errors();
    do_reset();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_reset: got %b expected 0", err);
    end
    drive_rsp(5);
    tick();
    no_rsp();
    checks++;
    if (bus.rsp_valid !== '0 || err !== 1'b1) begin
      errors++;
      $display("FAIL err_bad_tag: got rsp=%b err=%b expected rsp=0 err=1", bus.rsp_valid, err);
    end
    for (int c = 0; c < 3; c++) tick();
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got %b expected 1", err);
    end
    do_reset();
    drive_rsp(1);
    tick();
    no_rsp();
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_underflow: got %b expected 1", err);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; quiesce = 1'b0; stat_sel = '0;
    bus.req_valid = '0; bus.c0TxAlmFull = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0;
      obs_grants[i] = 0;
    end
    no_rsp();
    rand_req();
    test_reset();
    test_fairness();
    test_credit();
    test_almfull();
    test_drain();
    test_errors();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
